// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: access sizes, trap causes, FSM states.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    localparam logic [3:0] ECAUSE_BRANCH_MISALIGNED = 4'd0;
    localparam logic [3:0] ECAUSE_LOAD_MISALIGNED   = 4'd4;
    localparam logic [3:0] ECAUSE_LOAD_FAULT        = 4'd5;
    localparam logic [3:0] ECAUSE_STORE_MISALIGNED  = 4'd6;
    localparam logic [3:0] ECAUSE_STORE_FAULT       = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } mem_state_e;

    // Byte-enable pattern for an access of the given size, before lane shifting.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] mask;
        mask = 8'hFF;
        case (size)
            SIZE_B:  mask = 8'h01;
            SIZE_H:  mask = 8'h03;
            SIZE_W:  mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed lane out of a bus word and sign/zero-extends it to XLEN.
module load_extend
    import mem_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] data,
    input  logic [OFFW-1:0] offset,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] low_mask;
    logic            sign_bit;

    // Shift the addressed byte to bit 0, then mask and fill the upper bits.
    always_comb begin
        lane     = data >> {offset, 3'b000};
        low_mask = '1;
        sign_bit = lane[XLEN-1];
        unique case (size)
            SIZE_B: begin
                low_mask = XLEN'(8'hFF);
                sign_bit = lane[7];
            end
            SIZE_H: begin
                low_mask = XLEN'(16'hFFFF);
                sign_bit = lane[15];
            end
            SIZE_W: begin
                low_mask = XLEN'(32'hFFFF_FFFF);
                sign_bit = lane[31];
            end
            default: ;
        endcase
        result = (lane & low_mask) | ((sign_ext && sign_bit) ? ~low_mask : '0);
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: alignment traps, branch redirect, one outstanding bus
// transaction, and the register bank feeding writeback.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no transaction; non-memory or trapping ops retire here
// ST_REQ  | bus_req_valid high, waiting for bus_req_ready
// ST_RESP | request accepted, waiting for bus_rsp_valid
// ST_DONE | response captured; retires as soon as stall is low
module memory_stage
    import mem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [XLEN-1:0]   next_pc_in,
    input  logic [XLEN-1:0]   alu_data_in,
    input  logic [XLEN-1:0]   rs2_data_in,
    input  logic [XLEN-1:0]   csr_data_in,
    input  logic              branch_taken_in,
    input  logic              load_in,
    input  logic              store_in,
    input  logic              load_signed_in,
    input  logic              csr_write_in,
    input  logic              mret_in,
    input  logic              wfi_in,
    input  logic [1:0]        load_store_size_in,
    input  logic [1:0]        write_select_in,
    input  logic [4:0]        rd_address_in,
    input  logic [11:0]       csr_address_in,
    input  logic              valid_in,
    input  logic              exception_in,
    input  logic [3:0]        ecause_in,
    input  logic              stall,
    input  logic              invalidate,
    output logic              busy,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_wstrb,
    output logic              bus_write,
    input  logic              bus_rsp_valid,
    input  logic              bus_rsp_error,
    input  logic [XLEN-1:0]   bus_rsp_data,
    output logic              branch_taken,
    output logic [XLEN-1:0]   branch_address,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   next_pc_out,
    output logic [XLEN-1:0]   alu_data_out,
    output logic [XLEN-1:0]   csr_data_out,
    output logic [XLEN-1:0]   load_data_out,
    output logic [1:0]        write_select_out,
    output logic [4:0]        rd_address_out,
    output logic [11:0]       csr_address_out,
    output logic              csr_write_out,
    output logic              mret_out,
    output logic              wfi_out,
    output logic              valid_out,
    output logic [3:0]        ecause_out,
    output logic              exception_out
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    mem_state_e      state, state_next;
    logic            live, mem_op, misaligned, d_unsupported, mem_misaligned;
    logic            br_mis, ld_mis, st_mis, trap, issue, mem_done, keep;
    logic [OFFW-1:0] offset;
    logic [XLEN-1:0] store_data;
    logic [NB-1:0]   store_strb;
    logic            exc;
    logic [3:0]      cause;
    logic [OFFW-1:0] req_offset;
    logic [1:0]      req_size;
    logic            req_signed;
    logic [XLEN-1:0] ext_data, rsp_data;
    logic            rsp_error, kill;

    assign live   = valid_in && !exception_in && !invalidate;
    assign mem_op = load_in || store_in;
    assign offset = alu_data_in[OFFW-1:0];

    // Alignment of the requested access; D is only legal on a 64-bit datapath.
    always_comb begin
        misaligned = 1'b0;
        unique case (load_store_size_in)
            SIZE_B:  misaligned = 1'b0;
            SIZE_H:  misaligned = alu_data_in[0];
            SIZE_W:  misaligned = |alu_data_in[1:0];
            default: misaligned = (XLEN != 64) || (|alu_data_in[2:0]);
        endcase
    end

    // With alignment checking off, an unsupported D access still has to trap.
    assign d_unsupported  = (load_store_size_in == SIZE_D) && (XLEN != 64);
    assign mem_misaligned = CHECK_ALIGN ? misaligned : d_unsupported;

    assign br_mis   = live && branch_taken_in && (|alu_data_in[1:0]);
    assign ld_mis   = live && load_in && mem_misaligned;
    assign st_mis   = live && store_in && mem_misaligned;
    assign trap     = br_mis || ld_mis || st_mis;
    assign issue    = (state == ST_IDLE) && live && mem_op && !trap;
    assign mem_done = (state == ST_DONE);

    assign branch_taken   = live && branch_taken_in && (alu_data_in[1:0] == 2'b00) &&
                            (state == ST_IDLE);
    assign branch_address = alu_data_in;

    // Store payload: low bytes of rs2 replicated into every lane, strobe at the offset.
    always_comb begin
        store_data = rs2_data_in;
        unique case (load_store_size_in)
            SIZE_B:  store_data = {(XLEN / 8){rs2_data_in[7:0]}};
            SIZE_H:  store_data = {(XLEN / 16){rs2_data_in[15:0]}};
            SIZE_W:  store_data = {(XLEN / 32){rs2_data_in[31:0]}};
            default: ;
        endcase
        store_strb = NB'(size_mask(load_store_size_in)) << offset;
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .data     (bus_rsp_data),
        .offset   (req_offset),
        .size     (req_size),
        .sign_ext (req_signed),
        .result   (ext_data)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic and the busy indication to the hazard unit.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (issue) begin
                    state_next = ST_REQ;
                    busy       = 1'b1;
                end
            end
            ST_REQ: begin
                busy = 1'b1;
                if (bus_req_ready) state_next = ST_RESP;
            end
            ST_RESP: begin
                busy = 1'b1;
                if (bus_rsp_valid) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (!stall) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request payload is latched at issue and held until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req_valid <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            bus_wstrb     <= '0;
            bus_write     <= 1'b0;
            req_offset    <= '0;
            req_size      <= SIZE_B;
            req_signed    <= 1'b0;
        end else if (issue) begin
            bus_req_valid <= 1'b1;
            bus_addr      <= alu_data_in;
            bus_wdata     <= store_data;
            bus_wstrb     <= store_in ? store_strb : '0;
            bus_write     <= store_in;
            req_offset    <= offset;
            req_size      <= load_store_size_in;
            req_signed    <= load_signed_in;
        end else if ((state == ST_REQ) && bus_req_ready) begin
            bus_req_valid <= 1'b0;
        end
    end

    // Response capture; kill remembers an invalidate seen while the bus was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data  <= '0;
            rsp_error <= 1'b0;
            kill      <= 1'b0;
        end else begin
            if (issue) begin
                kill <= 1'b0;
            end else if (((state == ST_REQ) || (state == ST_RESP)) && invalidate) begin
                kill <= 1'b1;
            end
            if ((state == ST_RESP) && bus_rsp_valid) begin
                rsp_data  <= ext_data;
                rsp_error <= bus_rsp_error;
            end
        end
    end

    // Trap selection in priority order; bus faults only exist once a response is held.
    always_comb begin
        exc   = 1'b0;
        cause = '0;
        if (exception_in) begin
            exc   = 1'b1;
            cause = ecause_in;
        end else if (br_mis) begin
            exc   = 1'b1;
            cause = ECAUSE_BRANCH_MISALIGNED;
        end else if (ld_mis) begin
            exc   = 1'b1;
            cause = ECAUSE_LOAD_MISALIGNED;
        end else if (st_mis) begin
            exc   = 1'b1;
            cause = ECAUSE_STORE_MISALIGNED;
        end else if (mem_done && rsp_error) begin
            exc   = 1'b1;
            cause = load_in ? ECAUSE_LOAD_FAULT : ECAUSE_STORE_FAULT;
        end
    end

    assign keep = valid_in && !invalidate && !(mem_done && kill);

    // Writeback register bank; advances only when the stage retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out           <= '0;
            next_pc_out      <= '0;
            alu_data_out     <= '0;
            csr_data_out     <= '0;
            load_data_out    <= '0;
            write_select_out <= '0;
            rd_address_out   <= '0;
            csr_address_out  <= '0;
            csr_write_out    <= 1'b0;
            mret_out         <= 1'b0;
            wfi_out          <= 1'b0;
            valid_out        <= 1'b0;
            ecause_out       <= '0;
            exception_out    <= 1'b0;
        end else if (!stall && !busy) begin
            valid_out <= 1'b0;
            if (keep) begin
                pc_out           <= pc_in;
                next_pc_out      <= next_pc_in;
                alu_data_out     <= alu_data_in;
                csr_data_out     <= csr_data_in;
                load_data_out    <= (mem_done && load_in) ? rsp_data : '0;
                write_select_out <= write_select_in;
                rd_address_out   <= rd_address_in;
                csr_address_out  <= csr_address_in;
                csr_write_out    <= csr_write_in;
                mret_out         <= mret_in;
                wfi_out          <= wfi_in;
                valid_out        <= 1'b1;
                ecause_out       <= cause;
                exception_out    <= exc;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage (XLEN=32, CHECK_ALIGN=1): directed cases plus random
// instructions checked against a byte-level arithmetic model.
module tb_memory_stage;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in, next_pc_in, alu_data_in, rs2_data_in, csr_data_in;
    logic        branch_taken_in, load_in, store_in, load_signed_in;
    logic        csr_write_in, mret_in, wfi_in;
    logic [1:0]  load_store_size_in, write_select_in;
    logic [4:0]  rd_address_in;
    logic [11:0] csr_address_in;
    logic        valid_in, exception_in;
    logic [3:0]  ecause_in;
    logic        stall, invalidate;
    logic        busy, bus_req_valid, bus_req_ready;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_write, bus_rsp_valid, bus_rsp_error;
    logic [31:0] bus_rsp_data;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [31:0] pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out;
    logic [1:0]  write_select_out;
    logic [4:0]  rd_address_out;
    logic [11:0] csr_address_out;
    logic        csr_write_out, mret_out, wfi_out, valid_out, exception_out;
    logic [3:0]  ecause_out;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int last_busy_cnt = 0;

    always #5 clk = ~clk;

    memory_stage #(.XLEN(XLEN), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_in(pc_in), .next_pc_in(next_pc_in), .alu_data_in(alu_data_in),
        .rs2_data_in(rs2_data_in), .csr_data_in(csr_data_in),
        .branch_taken_in(branch_taken_in), .load_in(load_in), .store_in(store_in),
        .load_signed_in(load_signed_in), .csr_write_in(csr_write_in),
        .mret_in(mret_in), .wfi_in(wfi_in),
        .load_store_size_in(load_store_size_in), .write_select_in(write_select_in),
        .rd_address_in(rd_address_in), .csr_address_in(csr_address_in),
        .valid_in(valid_in), .exception_in(exception_in), .ecause_in(ecause_in),
        .stall(stall), .invalidate(invalidate), .busy(busy),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_write(bus_write), .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_error(bus_rsp_error), .bus_rsp_data(bus_rsp_data),
        .branch_taken(branch_taken), .branch_address(branch_address),
        .pc_out(pc_out), .next_pc_out(next_pc_out), .alu_data_out(alu_data_out),
        .csr_data_out(csr_data_out), .load_data_out(load_data_out),
        .write_select_out(write_select_out), .rd_address_out(rd_address_out),
        .csr_address_out(csr_address_out), .csr_write_out(csr_write_out),
        .mret_out(mret_out), .wfi_out(wfi_out), .valid_out(valid_out),
        .ecause_out(ecause_out), .exception_out(exception_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint nbytes(input logic [1:0] s);
        return longint'(1) << s;
    endfunction

    function automatic bit model_misaligned(input logic [31:0] a, input logic [1:0] s);
        if (nbytes(s) > XLEN / 8) return 1'b1;
        return (longint'(a) % nbytes(s)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] d, input logic [31:0] a,
                                               input logic [1:0] s, input bit sg);
        longint n, off, v;
        n   = nbytes(s);
        off = longint'(a) % 4;
        v   = (longint'(d) >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
        if (sg && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] rs2, input logic [1:0] s);
        longint n, val, w;
        n   = nbytes(s);
        val = longint'(rs2) & ((longint'(1) << (8 * n)) - 1);
        w   = 0;
        for (longint i = 0; i < 4 / n; i++) w = w | (val << (8 * n * i));
        return w[31:0];
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [31:0] a, input logic [1:0] s);
        longint m;
        m = ((longint'(1) << nbytes(s)) - 1) << (longint'(a) % 4);
        return m[3:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit ld, input bit st, input bit br, input bit sg,
                         input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] rs2);
        valid_in           = 1'b1;
        exception_in       = 1'b0;
        ecause_in          = 4'd0;
        load_in            = ld;
        store_in           = st;
        branch_taken_in    = br;
        load_signed_in     = sg;
        load_store_size_in = sz;
        alu_data_in        = addr;
        rs2_data_in        = rs2;
        pc_in              = $urandom;
        next_pc_in         = pc_in + 32'd4;
        csr_data_in        = $urandom;
        rd_address_in      = 5'($urandom_range(0, 31));
        csr_address_in     = 12'($urandom_range(0, 4095));
        write_select_in    = 2'($urandom_range(0, 3));
        csr_write_in       = 1'b0;
        mret_in            = 1'b0;
        wfi_in             = 1'b0;
    endtask

    task automatic idle_inputs();
        valid_in        = 1'b0;
        exception_in    = 1'b0;
        load_in         = 1'b0;
        store_in        = 1'b0;
        branch_taken_in = 1'b0;
        invalidate      = 1'b0;
        stall           = 1'b0;
        bus_req_ready   = 1'b0;
        bus_rsp_valid   = 1'b0;
        bus_rsp_error   = 1'b0;
        bus_rsp_data    = 32'h0;
    endtask

    // Runs the instruction currently on the inputs to retirement while acting as bus agent.
    // Called right after a falling edge with the instruction already driven.
    task automatic run_instr(input string tag, input int rdy_dly, input int rsp_dly,
                             input logic [31:0] rdata, input bit err, input bit inv_resp,
                             input int stall_n);
        bit         live, mem, br_mis, mis, goes_bus, exp_valid, exp_exc, retired;
        logic [3:0] exp_cause;
        int         cyc, busy_cnt, req_cycles, req_cnt, rsp_cnt, stall_left, exp_cyc;
        bit         hs, rdone, first;
        live      = valid_in && !exception_in && !invalidate;
        mem       = load_in || store_in;
        br_mis    = live && branch_taken_in && (alu_data_in % 4 != 0);
        mis       = live && mem && model_misaligned(alu_data_in, load_store_size_in);
        goes_bus  = live && mem && !mis && !br_mis;
        exp_valid = valid_in && !invalidate && !(goes_bus && inv_resp);
        exp_exc   = 1'b1;
        exp_cause = 4'd0;
        if (exception_in)          exp_cause = ecause_in;
        else if (br_mis)           exp_cause = 4'd0;
        else if (mis && load_in)   exp_cause = 4'd4;
        else if (mis)              exp_cause = 4'd6;
        else if (goes_bus && err)  exp_cause = load_in ? 4'd5 : 4'd7;
        else                       exp_exc = 1'b0;
        exp_cyc = goes_bus ? 4 + rdy_dly + rsp_dly + stall_n : 1 + stall_n;

        cyc = 0; busy_cnt = 0; req_cycles = 0; req_cnt = 0; rsp_cnt = 0;
        stall_left = stall_n; hs = 0; rdone = 0; first = 1; retired = 0;
        while (!retired && cyc < 80) begin
            bit hs_now, rsp_now, ret_now;
            bus_req_ready = bus_req_valid && (req_cnt >= rdy_dly);
            bus_rsp_valid = hs && !rdone && (rsp_cnt >= rsp_dly);
            bus_rsp_data  = bus_rsp_valid ? rdata : 32'h0;
            bus_rsp_error = bus_rsp_valid && err;
            invalidate    = inv_resp && hs && !rdone;
            #1;
            if (first) begin
                check({tag, ".branch_taken"}, branch_taken,
                      live && branch_taken_in && (alu_data_in % 4 == 0));
                if (branch_taken_in) check({tag, ".branch_address"}, branch_address, alu_data_in);
                first = 0;
            end
            if (bus_req_valid) req_cycles++;
            if (bus_req_valid && bus_req_ready) begin
                check({tag, ".bus_addr"}, bus_addr, alu_data_in);
                check({tag, ".bus_write"}, bus_write, store_in);
                if (store_in) begin
                    check({tag, ".bus_wstrb"}, bus_wstrb, model_wstrb(alu_data_in, load_store_size_in));
                    check({tag, ".bus_wdata"}, bus_wdata, model_wdata(rs2_data_in, load_store_size_in));
                end
            end
            if (busy) busy_cnt++;
            stall = !busy && (stall_left > 0);
            if (stall) stall_left--;
            hs_now  = bus_req_valid && bus_req_ready;
            rsp_now = bus_rsp_valid;
            ret_now = !busy && !stall;
            if (bus_req_valid && !bus_req_ready) req_cnt++;
            if (hs && !rdone && !rsp_now) rsp_cnt++;
            @(posedge clk);
            #1;
            if (hs_now) hs = 1;
            if (rsp_now) rdone = 1;
            cyc++;
            if (ret_now) retired = 1;
            else @(negedge clk);
        end
        last_busy_cnt = busy_cnt;
        check({tag, ".retired"}, retired, 1'b1);
        check({tag, ".latency"}, cyc, exp_cyc);
        check({tag, ".req_cycles"}, req_cycles, goes_bus ? rdy_dly + 1 : 0);
        check({tag, ".busy_cycles"}, busy_cnt, goes_bus ? 3 + rdy_dly + rsp_dly : 0);
        check({tag, ".valid_out"}, valid_out, exp_valid);
        if (exp_valid) begin
            check({tag, ".exception_out"}, exception_out, exp_exc);
            if (exp_exc) check({tag, ".ecause_out"}, ecause_out, exp_cause);
            check({tag, ".pc_out"}, pc_out, pc_in);
            check({tag, ".rd_address_out"}, rd_address_out, rd_address_in);
            if (goes_bus && load_in && !exp_exc)
                check({tag, ".load_data_out"}, load_data_out,
                      model_load(rdata, alu_data_in, load_store_size_in, load_signed_in));
        end
        @(negedge clk);
        idle_inputs();
    endtask

    // ---------------- directed sequence, then random ----------------
    initial begin
        rst_n = 1'b0;
        idle_inputs();
        drive(0, 0, 0, 0, 2'd0, 32'h0, 32'h0);
        valid_in = 1'b0;
        #12;
        check("reset.valid_out", valid_out, 1'b0);
        check("reset.exception_out", exception_out, 1'b0);
        check("reset.bus_req_valid", bus_req_valid, 1'b0);
        check("reset.load_data_out", load_data_out, 32'h0);
        check("reset.pc_out", pc_out, 32'h0);
        check("reset.busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        drive(1, 0, 0, 0, 2'd2, 32'h100, 32'h0);
        run_instr("lw", 0, 0, 32'hDEADBEEF, 0, 0, 0);
        check("lw.data_const", load_data_out, 32'hDEADBEEF);
        check("lw.busy_wait", last_busy_cnt - 1, 2);

        @(negedge clk);
        drive(1, 0, 0, 1, 2'd0, 32'h103, 32'h0);
        run_instr("lb", 0, 0, 32'h80FFFFFF, 0, 0, 0);
        check("lb.data_const", load_data_out, 32'hFFFFFF80);

        @(negedge clk);
        drive(1, 0, 0, 0, 2'd0, 32'h103, 32'h0);
        run_instr("lbu", 0, 0, 32'h80FFFFFF, 0, 0, 0);
        check("lbu.data_const", load_data_out, 32'h00000080);

        @(negedge clk);
        drive(0, 1, 0, 0, 2'd1, 32'h102, 32'h1234);
        run_instr("sh", 1, 1, 32'h0, 0, 0, 1);

        @(negedge clk);
        drive(1, 0, 0, 0, 2'd2, 32'h101, 32'h0);
        run_instr("lw_mis", 0, 0, 32'h0, 0, 0, 0);
        check("lw_mis.ecause_const", ecause_out, 4'd4);

        @(negedge clk);
        drive(0, 0, 1, 0, 2'd0, 32'h202, 32'h0);
        run_instr("br_mis", 0, 0, 32'h0, 0, 0, 0);
        check("br_mis.ecause_const", ecause_out, 4'd0);

        @(negedge clk);
        drive(0, 1, 0, 0, 2'd2, 32'h104, 32'hCAFEF00D);
        run_instr("sw_err", 3, 0, 32'h0, 1, 0, 0);
        check("sw_err.ecause_const", ecause_out, 4'd7);

        @(negedge clk);
        drive(1, 0, 0, 0, 2'd2, 32'h108, 32'h0);
        run_instr("lw_inv", 0, 1, 32'h12345678, 0, 1, 0);
        check("lw_inv.valid_const", valid_out, 1'b0);

        // Asynchronous reset in the middle of an outstanding request.
        @(negedge clk);
        drive(1, 0, 0, 0, 2'd2, 32'h10C, 32'h0);
        @(posedge clk);
        #1;
        check("rst_mid.req_before", bus_req_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.req_after", bus_req_valid, 1'b0);
        check("rst_mid.valid_out", valid_out, 1'b0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        for (int k = 0; k < 40; k++) begin
            int kind;
            logic [1:0] sz;
            logic [31:0] addr;
            kind = $urandom_range(0, 4);
            sz   = 2'($urandom_range(0, 3));
            addr = 32'h100 + 32'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1 && sz != 2'd3)
                addr = addr & ~(32'(nbytes(sz)) - 32'd1);
            @(negedge clk);
            drive(kind == 0, kind == 1, kind == 2, 1'($urandom_range(0, 1)), sz,
                  (kind == 2) ? 32'h200 + 32'($urandom_range(0, 3)) : addr, $urandom);
            if (kind == 4) valid_in = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                exception_in = 1'b1;
                ecause_in    = 4'($urandom_range(0, 15));
            end
            run_instr($sformatf("rnd%0d", k), $urandom_range(0, 3), $urandom_range(0, 2),
                      $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
